fpu_s_issue_ctrl: RTL and testbench



---
 rtl/fpu_s_issue_ctrl.sv | 123 ++++++++++++
 tb/tb_fpu_s_issue_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_s_issue_ctrl.sv
// fpu_s_issue_ctrl: issue/writeback sequencer for the single-precision FPU, owns fcsr
module fpu_s_issue_ctrl #(
    parameter logic [11:0] CSR_FFLAGS = 12'h001,
    parameter logic [11:0] CSR_FRM    = 12'h002,
    parameter logic [11:0] CSR_FCSR   = 12'h003
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic [31:0] rs3_i,
    input  logic [5:0]  op_i,
    input  logic [2:0]  rm_i,
    input  logic [4:0]  rd_i,
    input  logic        kill_i,
    output logic [31:0] fpu_rs1_o,
    output logic [31:0] fpu_rs2_o,
    output logic [31:0] fpu_rs3_o,
    output logic [5:0]  fpu_op_o,
    output logic [2:0]  fpu_frm_o,
    output logic        fpu_start_o,
    input  logic [31:0] fpu_c_i,
    input  logic [4:0]  fpu_fflags_i,
    input  logic        fpu_busy_i,
    output logic        wb_we_o,
    output logic [4:0]  wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic        stall_o,
    output logic        illegal_o,
    input  logic        csr_we_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] csr_wdata_i,
    output logic [31:0] csr_rdata_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;
    state_t      state, state_nx;
    logic [7:0]  fcsr, fcsr_nx;
    logic [31:0] res_q;
    logic [4:0]  flags_q, rd_q;
    logic [2:0]  rm_res;
    logic        rm_bad, accept, capture, wb_fire;
    logic        unused_wdata;
    assign unused_wdata = ^csr_wdata_i[31:8];
    // Handshake, rounding-mode resolution and writeback strobes
    always_comb begin
        rm_res      = (rm_i == 3'b111) ? fcsr[7:5] : rm_i;
        rm_bad      = rm_res >= 3'd5;
        ready_o     = state == IDLE;
        stall_o     = !ready_o;
        illegal_o   = ready_o && valid_i && !kill_i && rm_bad;
        accept      = ready_o && valid_i && !kill_i && !rm_bad;
        fpu_start_o = state == ISSUE;
        capture     = state == WAIT && !fpu_busy_i && !kill_i;
        wb_fire     = state == WB && !kill_i;
        wb_we_o     = wb_fire;
        wb_addr_o   = rd_q;
        wb_data_o   = res_q;
    end
    // Next-state logic; a flush from any busy state returns to IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = accept ? ISSUE : IDLE;
            ISSUE: state_nx = kill_i ? IDLE : WAIT;
            WAIT:  state_nx = kill_i ? IDLE : (fpu_busy_i ? WAIT : WB);
            WB:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // CSR write merge; completed-op flags are OR-ed in after any software write
    always_comb begin
        fcsr_nx = fcsr;
        if (csr_we_i && csr_addr_i == CSR_FFLAGS) fcsr_nx[4:0] = csr_wdata_i[4:0];
        if (csr_we_i && csr_addr_i == CSR_FRM)    fcsr_nx[7:5] = csr_wdata_i[2:0];
        if (csr_we_i && csr_addr_i == CSR_FCSR)   fcsr_nx      = csr_wdata_i[7:0];
        if (wb_fire) fcsr_nx[4:0] = fcsr_nx[4:0] | flags_q;
    end
    // CSR read mux; unmapped addresses and fcsr[31:8] read as zero
    always_comb begin
        csr_rdata_o = 32'b0;
        if (csr_addr_i == CSR_FFLAGS) csr_rdata_o = {27'b0, fcsr[4:0]};
        if (csr_addr_i == CSR_FRM)    csr_rdata_o = {29'b0, fcsr[7:5]};
        if (csr_addr_i == CSR_FCSR)   csr_rdata_o = {24'b0, fcsr};
    end
    // State and fcsr registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            fcsr  <= 8'b0;
        end else begin
            state <= state_nx;
            fcsr  <= fcsr_nx;
        end
    end
    // Operand latch on acceptance and result capture when the FPU goes idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpu_rs1_o <= 32'b0;
            fpu_rs2_o <= 32'b0;
            fpu_rs3_o <= 32'b0;
            fpu_op_o  <= 6'b0;
            fpu_frm_o <= 3'b0;
            rd_q      <= 5'b0;
            res_q     <= 32'b0;
            flags_q   <= 5'b0;
        end else begin
            if (accept) begin
                fpu_rs1_o <= rs1_i;
                fpu_rs2_o <= rs2_i;
                fpu_rs3_o <= rs3_i;
                fpu_op_o  <= op_i;
                fpu_frm_o <= rm_res;
                rd_q      <= rd_i;
            end
            if (capture) begin
                res_q   <= fpu_c_i;
                flags_q <= fpu_fflags_i;
            end
        end
    end
endmodule

// File: tb/tb_fpu_s_issue_ctrl.sv
// tb_fpu_s_issue_ctrl: randomized self-checking bench with a cycle-timeline reference model
module tb_fpu_s_issue_ctrl;
    localparam logic [5:0] FADD = 6'd0, FSUB = 6'd1;
    logic        clk = 0, rst_n = 0;
    logic        valid_i = 0, kill_i = 0, fpu_busy_i = 0, csr_we_i = 0;
    logic [31:0] rs1_i = 0, rs2_i = 0, rs3_i = 0, fpu_c_i = 0, csr_wdata_i = 0;
    logic [5:0]  op_i = 0;
    logic [2:0]  rm_i = 0;
    logic [4:0]  rd_i = 0, fpu_fflags_i = 0;
    logic [11:0] csr_addr_i = 0;
    logic        ready_o, fpu_start_o, wb_we_o, stall_o, illegal_o;
    logic [31:0] fpu_rs1_o, fpu_rs2_o, fpu_rs3_o, wb_data_o, csr_rdata_o;
    logic [5:0]  fpu_op_o;
    logic [2:0]  fpu_frm_o;
    logic [4:0]  wb_addr_o;
    int n_checks = 0, n_fail = 0;
    logic [2:0] m_frm = 0;
    logic [4:0] m_fflags = 0;

    fpu_s_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rs3_i(rs3_i), .op_i(op_i), .rm_i(rm_i), .rd_i(rd_i),
        .kill_i(kill_i), .fpu_rs1_o(fpu_rs1_o), .fpu_rs2_o(fpu_rs2_o), .fpu_rs3_o(fpu_rs3_o),
        .fpu_op_o(fpu_op_o), .fpu_frm_o(fpu_frm_o), .fpu_start_o(fpu_start_o),
        .fpu_c_i(fpu_c_i), .fpu_fflags_i(fpu_fflags_i), .fpu_busy_i(fpu_busy_i),
        .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .stall_o(stall_o),
        .illegal_o(illegal_o), .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i),
        .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o)
    );

    always #5 clk = ~clk;

    function automatic void m_csr(input logic [11:0] a, input logic [31:0] d);
        if (a == 12'h001) m_fflags = d[4:0];
        if (a == 12'h002) m_frm = d[2:0];
        if (a == 12'h003) {m_frm, m_fflags} = d[7:0];
    endfunction

    function automatic logic [31:0] m_rd(input logic [11:0] a);
        if (a == 12'h001) return {27'b0, m_fflags};
        if (a == 12'h002) return {29'b0, m_frm};
        if (a == 12'h003) return {24'b0, m_frm, m_fflags};
        return 32'b0;
    endfunction

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        csr_we_i = 1; csr_addr_i = a; csr_wdata_i = d;
        @(negedge clk);
        csr_we_i = 0;
        m_csr(a, d);
    endtask

    // One operation. Cycle 0 offers it; cycle 1 is ISSUE; the FPU is busy for busy_n cycles
    // from the start cycle, so the writeback lands in cycle 3 + busy_n.
    task automatic do_op(input logic [31:0] a, b, c3, input logic [5:0] op, input logic [2:0] rm,
                         input logic [4:0] rd, input int busy_n, input logic [31:0] res,
                         input logic [4:0] fl, input int kill_at, input int csr_cyc,
                         input logic [11:0] ca, input logic [31:0] cd);
        logic [2:0] rrm;
        int wbc;
        bit done;
        rrm = (rm == 3'b111) ? m_frm : rm;
        wbc = 3 + busy_n;
        done = 0;
        @(negedge clk);
        valid_i = 1; rs1_i = a; rs2_i = b; rs3_i = c3; op_i = op; rm_i = rm; rd_i = rd; kill_i = 0;
        csr_we_i = (csr_cyc == 0); csr_addr_i = ca; csr_wdata_i = cd;
        #1;
        n_checks++;
        if (ready_o !== 1'b1) begin n_fail++; $display("FAIL offer_ready got=%b exp=1", ready_o); end
        n_checks++;
        if (illegal_o !== (rrm >= 3'd5)) begin n_fail++; $display("FAIL illegal got=%b exp=%b rm=%0d", illegal_o, rrm >= 3'd5, rrm); end
        if (csr_cyc == 0) m_csr(ca, cd);
        if (rrm >= 3'd5) begin
            @(negedge clk);
            valid_i = 0; csr_we_i = 0;
            #1;
            n_checks++;
            if ({illegal_o, fpu_start_o, wb_we_o, stall_o, ready_o} !== 5'b00001)
                begin n_fail++; $display("FAIL illegal_after got=%b exp=00001", {illegal_o, fpu_start_o, wb_we_o, stall_o, ready_o}); end
            return;
        end
        for (int c = 1; c <= wbc && !done; c++) begin
            @(negedge clk);
            valid_i = 0; rs1_i = $urandom; rs2_i = $urandom; rm_i = 3'($urandom);
            kill_i = (c == kill_at);
            fpu_busy_i = (busy_n > 0) && (c < 2 + busy_n);
            fpu_c_i = (fpu_busy_i || c == wbc) ? $urandom : res;
            fpu_fflags_i = (fpu_busy_i || c == wbc) ? 5'($urandom) : fl;
            csr_we_i = (c == csr_cyc); csr_addr_i = ca; csr_wdata_i = cd;
            #1;
            n_checks++;
            if (fpu_start_o !== (c == 1)) begin n_fail++; $display("FAIL start c=%0d got=%b exp=%b", c, fpu_start_o, c == 1); end
            n_checks++;
            if (wb_we_o !== (c == wbc && kill_at != c)) begin n_fail++; $display("FAIL wb_we c=%0d got=%b exp=%b", c, wb_we_o, c == wbc && kill_at != c); end
            n_checks++;
            if ({stall_o, ready_o} !== 2'b10) begin n_fail++; $display("FAIL stall c=%0d got=%b exp=10", c, {stall_o, ready_o}); end
            n_checks++;
            if ({fpu_rs1_o, fpu_rs2_o, fpu_rs3_o, fpu_op_o, fpu_frm_o} !== {a, b, c3, op, rrm})
                begin n_fail++; $display("FAIL latched c=%0d got=%h/%h/%h/%h/%h exp=%h/%h/%h/%h/%h", c, fpu_rs1_o, fpu_rs2_o, fpu_rs3_o, fpu_op_o, fpu_frm_o, a, b, c3, op, rrm); end
            if (c == wbc && kill_at != c) begin
                n_checks++;
                if ({wb_addr_o, wb_data_o} !== {rd, res}) begin n_fail++; $display("FAIL wb_data got=%h@%0d exp=%h@%0d", wb_data_o, wb_addr_o, res, rd); end
            end
            if (c == csr_cyc) m_csr(ca, cd);
            if (c == wbc && kill_at != c) m_fflags = m_fflags | fl;
            if (c == kill_at) done = 1;
        end
        @(negedge clk);
        kill_i = 0; fpu_busy_i = 0; csr_we_i = 0; csr_addr_i = 12'h001;
        #1;
        n_checks++;
        if ({stall_o, ready_o, wb_we_o, fpu_start_o} !== 4'b0100) begin n_fail++; $display("FAIL end_idle got=%b exp=0100", {stall_o, ready_o, wb_we_o, fpu_start_o}); end
        n_checks++;
        if (fpu_rs1_o !== a) begin n_fail++; $display("FAIL hold_rs1 got=%h exp=%h", fpu_rs1_o, a); end
        n_checks++;
        if (csr_rdata_o !== m_rd(12'h001)) begin n_fail++; $display("FAIL fflags got=%h exp=%h", csr_rdata_o, m_rd(12'h001)); end
    endtask

    task automatic test_reset;
        #1;
        n_checks++;
        if ({ready_o, stall_o, fpu_start_o, wb_we_o, illegal_o} !== 5'b10000)
            begin n_fail++; $display("FAIL reset_ctl got=%b exp=10000", {ready_o, stall_o, fpu_start_o, wb_we_o, illegal_o}); end
        n_checks++;
        if ({fpu_rs1_o, fpu_rs2_o, fpu_rs3_o, fpu_op_o, fpu_frm_o, wb_addr_o, wb_data_o} !== '0)
            begin n_fail++; $display("FAIL reset_data got=%h exp=0", {fpu_rs1_o, fpu_rs2_o, fpu_rs3_o, fpu_op_o, fpu_frm_o, wb_addr_o, wb_data_o}); end
        csr_addr_i = 12'h003;
        #1;
        n_checks++;
        if (csr_rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_fcsr got=%h exp=0", csr_rdata_o); end
    endtask

    task automatic test_fadd;
        do_op(32'h3F800000, 32'h40000000, 0, FADD, 3'b000, 5'd5, 1, 32'h40400000, 5'h00, -1, -1, 0, 0);
        do_op(32'h3F800000, 32'h3F800000, 0, 6'd9, 3'b001, 5'd17, 0, 32'h3F800000, 5'h00, -1, -1, 0, 0);
    endtask

    task automatic test_sticky;
        do_op(32'h7F800000, 32'h7F800000, 0, FSUB, 3'b000, 5'd3, 1, 32'h7FC00000, 5'h10, -1, -1, 0, 0);
        do_op(32'h3F800000, 32'h40000000, 0, FADD, 3'b000, 5'd4, 1, 32'h40400000, 5'h00, -1, -1, 0, 0);
    endtask

    task automatic test_illegal;
        csr_write(12'h002, 32'h5);
        do_op(32'h1, 32'h2, 32'h3, FADD, 3'b111, 5'd6, 1, 32'h0, 5'h1F, -1, -1, 0, 0);
        do_op(32'h1, 32'h2, 32'h3, FADD, 3'b110, 5'd6, 1, 32'h0, 5'h1F, -1, -1, 0, 0);
        csr_write(12'h002, 32'h3);
        do_op(32'hA, 32'hB, 32'hC, FADD, 3'b111, 5'd7, 1, 32'h11223344, 5'h02, -1, 0, 12'h002, 32'h6);
        csr_write(12'h002, 32'h0);
    endtask

    task automatic test_kill;
        do_op(32'h3F800000, 32'h40000000, 0, FADD, 3'b000, 5'd8, 1, 32'h40400000, 5'h08, 2, -1, 0, 0);
        do_op(32'h3F800000, 32'h40000000, 0, FADD, 3'b000, 5'd8, 1, 32'h40400000, 5'h04, 1, -1, 0, 0);
        do_op(32'h3F800000, 32'h40000000, 0, FADD, 3'b000, 5'd8, 0, 32'h40400000, 5'h02, 3, -1, 0, 0);
        @(negedge clk);
        valid_i = 1; kill_i = 1; rm_i = 3'b000;
        @(negedge clk);
        valid_i = 0; kill_i = 0;
        #1;
        n_checks++;
        if ({stall_o, fpu_start_o} !== 2'b00) begin n_fail++; $display("FAIL kill_idle got=%b exp=00", {stall_o, fpu_start_o}); end
    endtask

    task automatic test_csr;
        csr_write(12'h003, 32'hFFFFFFFF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            csr_addr_i = 12'(i);
            #1;
            n_checks++;
            if (csr_rdata_o !== m_rd(12'(i))) begin n_fail++; $display("FAIL csr_read a=%0d got=%h exp=%h", i, csr_rdata_o, m_rd(12'(i))); end
        end
        do_op(32'h1, 32'h2, 32'h3, FADD, 3'b000, 5'd9, 1, 32'h55, 5'h01, -1, 4, 12'h001, 32'h0);
        csr_write(12'h003, 32'h0);
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        valid_i = 1; rs1_i = 32'hDEAD; rs2_i = 32'hBEEF; op_i = FADD; rm_i = 3'b000; rd_i = 5'd2;
        csr_we_i = 1; csr_addr_i = 12'h003; csr_wdata_i = 32'hE5;
        @(negedge clk);
        valid_i = 0; csr_we_i = 0; fpu_busy_i = 1;
        @(negedge clk);
        #1;
        rst_n = 0;
        #1;
        n_checks++;
        if ({ready_o, stall_o, fpu_start_o, wb_we_o, illegal_o} !== 5'b10000)
            begin n_fail++; $display("FAIL areset_ctl got=%b exp=10000", {ready_o, stall_o, fpu_start_o, wb_we_o, illegal_o}); end
        n_checks++;
        if ({fpu_rs1_o, fpu_rs2_o, fpu_op_o, wb_addr_o, wb_data_o, csr_rdata_o} !== '0)
            begin n_fail++; $display("FAIL areset_data got=%h exp=0", {fpu_rs1_o, fpu_rs2_o, fpu_op_o, wb_addr_o, wb_data_o, csr_rdata_o}); end
        m_frm = 0; m_fflags = 0; fpu_busy_i = 0;
        @(negedge clk);
        rst_n = 1;
        do_op(32'h3F800000, 32'h40000000, 0, FADD, 3'b111, 5'd1, 1, 32'h40400000, 5'h01, -1, -1, 0, 0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            int r, bn, ka, cc;
            logic [2:0] rm;
            if (i % 7 == 3) csr_write(12'h002, $urandom_range(0, 7));
            r = $urandom_range(0, 5);
            rm = (r == 5) ? 3'b111 : 3'(r);
            bn = $urandom_range(0, 3);
            ka = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3 + bn) : -1;
            cc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3 + bn) : -1;
            do_op($urandom, $urandom, $urandom, 6'($urandom), rm, 5'($urandom), bn, $urandom,
                  5'($urandom), ka, cc, 12'($urandom_range(1, 3)), $urandom);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1;
        test_reset;
        test_fadd;
        test_sticky;
        test_illegal;
        test_kill;
        test_csr;
        test_async_reset;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
